// File: rtl/inference_sequencer.sv
// Run sequencer for the image-classification accelerator: kicks the image glue,
// watches the image stream, waits out the accelerator latency and captures the class.
module inference_sequencer #(
  parameter int BEATS = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_weights_ready,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_cfg_latency,
  input  logic [CNT_W-1:0] i_cfg_timeout,
  input  logic             i_tvalid,
  input  logic             i_tready,
  input  logic             i_tlast,
  input  logic [3:0]       i_acc_result,
  input  logic             i_irq_clr,
  output logic             o_img_cmd_pulse,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_result,
  output logic             o_result_valid,
  output logic [2:0]       o_err,
  output logic [3:0]       o_beat_cnt,
  output logic             o_irq,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_KICK    = 3'd1,
    S_STREAM  = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  localparam logic [4:0] LP_BEATS      = 5'(BEATS);
  localparam logic [2:0] ERR_OK        = 3'b000;
  localparam logic [2:0] ERR_NOT_READY = 3'b001;
  localparam logic [2:0] ERR_FRAMING   = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT   = 3'b011;
  localparam logic [2:0] ERR_ABORT     = 3'b100;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;

  logic             w_beat;
  logic [4:0]       w_beat_inc;
  logic [3:0]       w_beat_sat;
  logic [CNT_W-1:0] w_timer_inc;
  logic             w_last_beat;
  logic             w_timeout;

  // The stream is only monitored: a beat is any cycle with i_tvalid and i_tready
  // both high; this block never drives either side of that handshake.
  assign w_beat      = i_tvalid & i_tready;
  assign w_beat_inc  = {1'b0, o_beat_cnt} + 5'd1;
  assign w_beat_sat  = (o_beat_cnt == 4'hF) ? o_beat_cnt : w_beat_inc[3:0];
  assign w_timer_inc = (r_timer == '1) ? r_timer : r_timer + CNT_W'(1);
  assign w_last_beat = (w_beat_inc == LP_BEATS);
  // The timer shares its register between idle-gap counting and the latency wait.
  assign w_timeout   = (i_cfg_timeout != '0) && (w_timer_inc == i_cfg_timeout);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_timer         <= '0;
      o_img_cmd_pulse <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_result        <= 4'h0;
      o_result_valid  <= 1'b0;
      o_err           <= ERR_OK;
      o_beat_cnt      <= 4'h0;
      o_irq           <= 1'b0;
    end else begin
      o_done          <= 1'b0;
      o_img_cmd_pulse <= 1'b0;
      if (i_irq_clr) o_irq <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && i_weights_ready) begin
            r_state         <= S_KICK;
            o_img_cmd_pulse <= 1'b1;
            o_busy          <= 1'b1;
            o_beat_cnt      <= 4'h0;
            r_timer         <= '0;
            o_result_valid  <= 1'b0;
          end else if (i_start) begin
            o_err  <= ERR_NOT_READY;
            o_done <= 1'b1;
            o_irq  <= 1'b1;
          end
        end
        S_KICK: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
            o_err   <= ERR_ABORT;
            o_done  <= 1'b1;
            o_irq   <= 1'b1;
          end else begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
            o_err   <= ERR_ABORT;
            o_done  <= 1'b1;
            o_irq   <= 1'b1;
          end else if (w_beat) begin
            o_beat_cnt <= w_beat_sat;
            r_timer    <= '0;
            if (i_tlast && w_last_beat) begin
              r_state <= S_WAIT;
            end else if (i_tlast || w_last_beat) begin
              r_state <= S_IDLE;
              o_busy  <= 1'b0;
              o_err   <= ERR_FRAMING;
              o_done  <= 1'b1;
              o_irq   <= 1'b1;
            end
          end else begin
            r_timer <= w_timer_inc;
            if (w_timeout) begin
              r_state <= S_IDLE;
              o_busy  <= 1'b0;
              o_err   <= ERR_TIMEOUT;
              o_done  <= 1'b1;
              o_irq   <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
            o_err   <= ERR_ABORT;
            o_done  <= 1'b1;
            o_irq   <= 1'b1;
          end else if (r_timer == i_cfg_latency) begin
            r_state <= S_CAPTURE;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_CAPTURE: begin
          r_state        <= S_IDLE;
          o_busy         <= 1'b0;
          o_result       <= i_acc_result;
          o_result_valid <= 1'b1;
          o_err          <= ERR_OK;
          o_done         <= 1'b1;
          o_irq          <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed and randomized runs of inference_sequencer against an outcome model
// that derives each run's result from its beat/gap plan.
module tb_inference_sequencer;
  localparam int BEATS = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_weights_ready, i_abort;
  logic [CNT_W-1:0] i_cfg_latency, i_cfg_timeout;
  logic             i_tvalid, i_tready, i_tlast;
  logic [3:0]       i_acc_result;
  logic             i_irq_clr;
  logic             o_img_cmd_pulse, o_busy, o_done, o_result_valid, o_irq;
  logic [3:0]       o_result, o_beat_cnt;
  logic [2:0]       o_err, o_dbg_state;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] m_result = 4'h0;

  inference_sequencer #(.BEATS(BEATS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_weights_ready(i_weights_ready),
    .i_abort(i_abort), .i_cfg_latency(i_cfg_latency), .i_cfg_timeout(i_cfg_timeout),
    .i_tvalid(i_tvalid), .i_tready(i_tready), .i_tlast(i_tlast),
    .i_acc_result(i_acc_result), .i_irq_clr(i_irq_clr),
    .o_img_cmd_pulse(o_img_cmd_pulse), .o_busy(o_busy), .o_done(o_done),
    .o_result(o_result), .o_result_valid(o_result_valid), .o_err(o_err),
    .o_beat_cnt(o_beat_cnt), .o_irq(o_irq), .o_dbg_state(o_dbg_state)
  );

  // clock / time limit
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    i_start   = 1'b0;
    i_abort   = 1'b0;
    i_tvalid  = 1'b0;
    i_tready  = 1'b0;
    i_tlast   = 1'b0;
    i_irq_clr = 1'b0;
  endtask

  // One run: nb planned beats, tlast on beat tl_at (0 = never), random gaps up to
  // gmax, optional forced gap before beat fk, optional abort at edge abort_in.
  task automatic do_run(input int nb, input int tl_at, input int gmax, input int fk,
                        input int fgap, input int lat, input int to, input int abort_in,
                        input bit clr_at_abort, input string tag);
    int         gaps[1:BEATS];
    int         p[0:BEATS];
    int         n_acc, exp_done, exp_err, exp_cnt, abort_at, done_e, r;
    bit         exp_ok, beat_now, tl_now;
    logic [3:0] res;
    res      = 4'($urandom_range(0, 15));
    n_acc    = 0;
    exp_done = -1;
    exp_err  = 0;
    exp_cnt  = 0;
    exp_ok   = 1'b0;
    abort_at = abort_in;
    p[0]     = 1;
    for (int k = 1; k <= BEATS; k++) gaps[k] = $urandom_range(0, gmax);
    if (fk > 0) gaps[fk] = fgap;

    // Edge 0 samples start, edge 1 leaves KICK, beat k lands on edge p[k].
    for (int k = 1; k <= nb && exp_done < 0; k++) begin
      if (to != 0 && gaps[k] >= to) begin
        exp_done = p[k-1] + to; exp_err = 3; exp_cnt = k - 1;
      end else begin
        p[k]  = p[k-1] + gaps[k] + 1;
        n_acc = k;
        if (k == tl_at || k == BEATS) begin
          exp_ok   = (k == tl_at && k == BEATS);
          exp_done = exp_ok ? p[k] + lat + 2 : p[k];
          exp_err  = exp_ok ? 0 : 2;
          exp_cnt  = k;
        end
      end
    end
    if (exp_done < 0) begin
      if (to != 0) begin
        exp_done = p[n_acc] + to; exp_err = 3; exp_cnt = n_acc;
      end else if (abort_at == 0) begin
        abort_at = p[n_acc] + 30;
      end
    end
    if (abort_at > 0 && (exp_done < 0 || abort_at < exp_done || (abort_at == exp_done && !exp_ok))) begin
      exp_done = abort_at; exp_err = 4; exp_ok = 1'b0; exp_cnt = 0;
      for (int k = 1; k <= n_acc; k++) if (p[k] < abort_at) exp_cnt++;
    end

    i_cfg_latency   = CNT_W'(lat);
    i_cfg_timeout   = CNT_W'(to);
    i_acc_result    = res;
    i_weights_ready = 1'b1;
    i_start         = 1'b1;
    step();
    chk({tag, " cmd_pulse"}, o_img_cmd_pulse, 1);
    chk({tag, " busy_kick"}, o_busy, 1);
    chk({tag, " valid_cleared"}, o_result_valid, 0);

    done_e = -1;
    for (int e = 1; e <= exp_done + 3 && done_e < 0; e++) begin
      beat_now = 1'b0;
      tl_now   = 1'b0;
      for (int k = 1; k <= n_acc; k++) if (p[k] == e) begin beat_now = 1'b1; tl_now = (k == tl_at); end
      if (beat_now) begin
        i_tvalid = 1'b1; i_tready = 1'b1; i_tlast = tl_now;
      end else begin
        r = $urandom_range(0, 2);
        i_tvalid = (r == 1); i_tready = (r == 2); i_tlast = 1'($urandom_range(0, 1));
      end
      i_start   = (e <= exp_done) && ($urandom_range(0, 3) == 0);
      i_abort   = (e == abort_at);
      i_irq_clr = (e == exp_done) ? ((e == abort_at) ? clr_at_abort : 1'($urandom_range(0, 1))) : 1'b0;
      step();
      if (e == 1) chk({tag, " pulse_one_cycle"}, o_img_cmd_pulse, 0);
      if (o_done) done_e = e;
    end
    idle_inputs();

    chk({tag, " done_edge"}, done_e, exp_done);
    chk({tag, " err"}, o_err, exp_err);
    chk({tag, " beat_cnt"}, o_beat_cnt, exp_cnt);
    chk({tag, " result_valid"}, o_result_valid, exp_ok);
    chk({tag, " result"}, o_result, exp_ok ? res : m_result);
    chk({tag, " irq"}, o_irq, 1);
    chk({tag, " busy_end"}, o_busy, 0);
    if (exp_ok) m_result = res;
    i_irq_clr = 1'b1;
    step();
    i_irq_clr = 1'b0;
    chk({tag, " irq_clr"}, o_irq, 0);
    chk({tag, " done_pulse"}, o_done, 0);
  endtask

  initial begin
    int sc, tl, nb, to, lat, fk, fg, ab;
    idle_inputs();
    rst             = 1'b1;
    i_weights_ready = 1'b1;
    i_cfg_latency   = '0;
    i_cfg_timeout   = '0;
    i_acc_result    = 4'h0;
    step();
    step();
    chk("rst cmd_pulse", o_img_cmd_pulse, 0);
    chk("rst busy", o_busy, 0);
    chk("rst done", o_done, 0);
    chk("rst result", o_result, 0);
    chk("rst result_valid", o_result_valid, 0);
    chk("rst err", o_err, 0);
    chk("rst beat_cnt", o_beat_cnt, 0);
    chk("rst irq", o_irq, 0);
    chk("rst state", o_dbg_state, 0);
    rst = 1'b0;
    step();

    do_run(8, 8, 0, 0, 0, 5, 0, 0, 1'b0, "nominal");

    i_weights_ready = 1'b0;
    i_start         = 1'b1;
    step();
    i_start = 1'b0;
    chk("notready done", o_done, 1);
    chk("notready err", o_err, 1);
    chk("notready busy", o_busy, 0);
    chk("notready cmd_pulse", o_img_cmd_pulse, 0);
    chk("notready irq", o_irq, 1);
    chk("notready result_kept", o_result_valid, 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("idle_abort done", o_done, 0);
    chk("idle_abort err_held", o_err, 1);
    chk("idle_abort busy", o_busy, 0);
    i_irq_clr = 1'b1;
    step();
    i_irq_clr       = 1'b0;
    i_weights_ready = 1'b1;
    chk("notready irq_clr", o_irq, 0);

    do_run(5, 5, 0, 0, 0, 3, 0, 0, 1'b0, "early_tlast");
    do_run(3, 0, 0, 0, 0, 2, 10, 0, 1'b0, "timeout10");
    do_run(3, 0, 0, 0, 0, 2, 0, 0, 1'b0, "timeout0_stall");
    do_run(8, 8, 0, 0, 0, 5, 0, 12, 1'b1, "abort_wait");
    do_run(8, 8, 0, 0, 0, 5, 0, 1, 1'b0, "abort_kick");
    do_run(8, 8, 0, 0, 0, 0, 0, 0, 1'b0, "latency0");

    // reset in the middle of a stream
    i_start = 1'b1;
    step();
    i_start  = 1'b0;
    i_tvalid = 1'b1;
    i_tready = 1'b1;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    idle_inputs();
    chk("rst_mid busy", o_busy, 0);
    chk("rst_mid done", o_done, 0);
    chk("rst_mid result", o_result, 0);
    chk("rst_mid result_valid", o_result_valid, 0);
    chk("rst_mid err", o_err, 0);
    chk("rst_mid beat_cnt", o_beat_cnt, 0);
    chk("rst_mid irq", o_irq, 0);
    chk("rst_mid state", o_dbg_state, 0);
    rst      = 1'b0;
    m_result = 4'h0;
    step();
    step();
    chk("rst_mid no_done", o_done, 0);
    chk("rst_mid idle", o_busy, 0);

    for (int i = 0; i < 14; i++) begin
      sc  = $urandom_range(0, 4);
      lat = $urandom_range(0, 6);
      to  = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 9) : 0;
      nb = 8; tl = 8; fk = 0; fg = 0; ab = 0;
      case (sc)
        1: begin tl = $urandom_range(1, BEATS - 1); nb = tl; end
        2: tl = 0;
        3: begin to = $urandom_range(2, 6); fk = $urandom_range(1, BEATS); fg = to + $urandom_range(0, 2); end
        4: ab = $urandom_range(1, 20);
        default: ;
      endcase
      do_run(nb, tl, (sc == 3) ? 1 : 3, fk, fg, lat, to, ab, 1'($urandom_range(0, 1)), $sformatf("rand%0d_sc%0d", i, sc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
